// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: ROM address/data, redirect request and the decode-facing
// valid/ready instruction channel.
interface fetch_unit_if;
  logic [29:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  modport master (
    output imem_pc,
    input  imem_inst,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc
  );

  modport slave (
    input  imem_pc,
    output imem_inst,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the synchronous-read ROM address, tracks the
// single in-flight read and buffers returned {pc, inst} pairs for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_pc_q;
  logic [31:0] fifo_pc_q   [2];
  logic [31:0] fifo_inst_q [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;

  assign bus.out_valid = (count_q != 2'd0);
  assign pop           = bus.out_valid && bus.out_ready;
  assign push          = req_valid_q;

  // Entries held after this edge, with the outstanding read counted as a
  // reserved slot; a new read is only launched if a slot remains for it.
  assign occupancy = {1'b0, count_q} + {2'b0, req_valid_q} - {2'b0, pop};
  assign issue     = (occupancy <= 3'd1);

  assign bus.imem_pc  = fetch_pc_q[31:2];
  assign bus.out_pc   = bus.out_valid ? fifo_pc_q[rd_ptr_q]   : 32'd0;
  assign bus.out_inst = bus.out_valid ? fifo_inst_q[rd_ptr_q] : 32'd0;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_valid_d = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      count_d    = 2'd0;
    end else begin
      if (issue) begin
        req_valid_d = 1'b1;
        fetch_pc_d  = fetch_pc_q + 32'd4;
      end
      if (push) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = occupancy[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      req_valid_q <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_valid_q <= req_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Data path carries no reset; stale contents are masked by count/req_valid.
  always_ff @(posedge clk) begin
    if (issue && !bus.redirect_valid) begin
      req_pc_q <= fetch_pc_q;
    end
    if (push && !bus.redirect_valid) begin
      fifo_pc_q[wr_ptr_q]   <= req_pc_q;
      fifo_inst_q[wr_ptr_q] <= bus.imem_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ({1'b0, count_q} + {2'b0, req_valid_q} <= 3'd2);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a ROM model feeds the DUT and
// the delivered {pc, inst} stream is compared against an expected-stream queue.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          FILL   = 256;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  logic mon_en = 1'b0;
  logic hold_prev = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] rom_word(input logic [29:0] a);
    return 32'h1000_0000 + {2'b00, a};
  endfunction

  // Synchronous-read ROM: data for the address presented now appears next cycle.
  always @(posedge clk) bus.imem_inst <= rom_word(bus.imem_pc);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected delivery after a restart: consecutive words from the aligned start.
  task automatic refill(input logic [31:0] start);
    logic [31:0] pc;
    exp_q.delete();
    for (int i = 0; i < FILL; i++) begin
      pc = (start & 32'hFFFF_FFFC) + 32'(4 * i);
      exp_q.push_back('{pc: pc, inst: rom_word(pc[31:2])});
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (hold_prev) check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
      if (!bus.out_valid) begin
        check("idle_pc", bus.out_pc, 32'd0);
        check("idle_inst", bus.out_inst, 32'd0);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_overrun: got pc %h expected no more output", bus.out_pc);
      end else begin
        e = exp_q[0];
        check("head_pc", bus.out_pc, e.pc);
        check("head_inst", bus.out_inst, e.inst);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready && !bus.redirect_valid && !rst;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_end(input logic [31:0] target);
    @(negedge clk);
    #1;
    refill(target);
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = $urandom;
    check("redir_imem_pc", {2'b00, bus.imem_pc}, {2'b00, target[31:2]});
    check("redir_gap1", {31'b0, bus.out_valid}, 32'd0);
    cyc();
    check("redir_gap2", {31'b0, bus.out_valid}, 32'd0);
    cyc();
    check("redir_first_valid", {31'b0, bus.out_valid}, 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    redirect_end(target);
  endtask

  task automatic do_redirect2(input logic [31:0] a, input logic [31:0] b);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = a;
    cyc();
    bus.redirect_pc    = b;
    redirect_end(b);
  endtask

  task automatic do_reset();
    logic [31:0] rst_word;
    rst_word = RST_PC >> 2;
    rst = 1'b1;
    @(negedge clk);
    #1;
    refill(RST_PC);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    check("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_pc", bus.out_pc, 32'd0);
    check("rst_inst", bus.out_inst, 32'd0);
    check("rst_imem_pc", {2'b00, bus.imem_pc}, rst_word);
    cyc();
    check("rel_c1_valid", {31'b0, bus.out_valid}, 32'd0);
    cyc();
    check("rel_c2_valid", {31'b0, bus.out_valid}, 32'd1);
  endtask

  initial begin
    int since;
    int r;
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.out_ready      = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Stream from reset with decode always ready: no bubbles.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("stream_valid", {31'b0, bus.out_valid}, 32'd1);
    end

    // Backpressure: fetch parks two words beyond the held head.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("stall_imem_pc", {2'b00, bus.imem_pc}, (exp_q[0].pc + 32'd8) >> 2);
    end
    bus.out_ready = 1'b1;
    repeat (6) cyc();

    // Redirect with the buffer full, then with a read in flight.
    bus.out_ready = 1'b0;
    repeat (3) cyc();
    do_redirect(32'h0000_0040);
    bus.out_ready = 1'b1;
    repeat (4) cyc();
    do_redirect(32'h0000_0043);
    repeat (4) cyc();
    do_redirect2(32'h0000_0200, 32'h0000_0300);
    repeat (4) cyc();

    // Address wrap at the top of the space.
    do_redirect(32'hFFFF_FFF8);
    repeat (6) cyc();

    // Reset mid-stream with a toggling consumer and a competing redirect.
    for (int i = 0; i < 5; i++) begin
      bus.out_ready = ~bus.out_ready;
      cyc();
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0800;
    do_reset();

    since = 0;
    for (int c = 0; c < 1500; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset();
        since = 0;
      end else if (r < 6 || since > 150) begin
        do_redirect($urandom);
        since = 0;
      end else if (r == 6) begin
        do_redirect2($urandom, $urandom);
        since = 0;
      end else begin
        cyc();
        since++;
      end
    end

    check("enough_transfers", (pops >= 300) ? 32'd1 : 32'd0, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
